// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and the cache top levels.
// Holds the arbiter state encoding and the default line/address widths.
package dmem_pkg;

    localparam int DMEM_DATA_W = 256;
    localparam int DMEM_ADDR_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser: on a tie the requester that was not served
// last wins, otherwise the single active requester is picked.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_valid_o,
    output logic       grant_idx_o
);

    always_comb begin
        grant_valid_o = |req_i;
        if (req_i == 2'b11) begin
            grant_idx_o = ~last_grant_i;
        end else begin
            grant_idx_o = req_i[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one line-wide data memory port between two
// requesters; a grant stays locked while its owner holds enable.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,

    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    arb_state_e state_q, state_d;
    logic       lastGrant_q, lastGrant_d;
    logic       pickValid;
    logic       pickIdx;

    rr_pick2 u_pick (
        .req_i        ({m1_enable_i, m0_enable_i}),
        .last_grant_i (lastGrant_q),
        .grant_valid_o(pickValid),
        .grant_idx_o  (pickIdx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            lastGrant_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    // Grants are only taken from IDLE, which forces a bubble between owners.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        case (state_q)
            ARB_IDLE: begin
                if (pickValid) begin
                    state_d     = pickIdx ? ARB_GRANT1 : ARB_GRANT0;
                    lastGrant_d = pickIdx;
                end
            end
            ARB_GRANT0: begin
                if (!m0_enable_i) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT1: begin
                if (!m1_enable_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Outputs are forced quiet during reset so an abandoned grant never leaks.
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        m0_ack_o     = 1'b0;
        m1_ack_o     = 1'b0;
        if (!rst_i) begin
            case (state_q)
                ARB_GRANT0: begin
                    mem_enable_o = m0_enable_i;
                    mem_write_o  = m0_write_i;
                    mem_addr_o   = m0_addr_i;
                    mem_data_o   = m0_data_i;
                    m0_ack_o     = mem_ack_i;
                end
                ARB_GRANT1: begin
                    mem_enable_o = m1_enable_i;
                    mem_write_o  = m1_write_i;
                    mem_addr_o   = m1_addr_i;
                    mem_data_o   = m1_data_i;
                    m1_ack_o     = mem_ack_i;
                end
                default: begin
                    mem_enable_o = 1'b0;
                end
            endcase
        end
    end

    assign m0_data_o = mem_data_i;
    assign m1_data_o = mem_data_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table for the
// multi-cycle corner cases, then randomized traffic against an ownership model.
module tb_dmem_arbiter;

    localparam int DW = 256;
    localparam int AW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [DW-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o;
    logic          m0_ack_o, m1_ack_o;
    logic          mem_enable_o, mem_write_o, mem_ack_i;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o, mem_data_i;

    int checks   = 0;
    int failures = 0;

    // Model: which requester owns the memory (-1 none) and who was served last.
    int mOwner = -1;
    bit mLast  = 1'b1;

    typedef struct {
        logic          rst, en0, wr0;
        logic [AW-1:0] a0;
        logic          en1;
        logic [AW-1:0] a1;
        logic          ack;
        logic          eEn, eWr;
        logic [AW-1:0] eAddr;
        logic          eAck0, eAck1;
    } vec_t;

    vec_t vecs[$];

    always #5 clk_i = ~clk_i;

    dmem_arbiter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .m0_enable_i (m0_enable_i),
        .m0_write_i  (m0_write_i),
        .m0_addr_i   (m0_addr_i),
        .m0_data_i   (m0_data_i),
        .m0_data_o   (m0_data_o),
        .m0_ack_o    (m0_ack_o),
        .m1_enable_i (m1_enable_i),
        .m1_write_i  (m1_write_i),
        .m1_addr_i   (m1_addr_i),
        .m1_data_i   (m1_data_i),
        .m1_data_o   (m1_data_o),
        .m1_ack_o    (m1_ack_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
    );

    function automatic void v(input logic rst, en0, wr0, input logic [AW-1:0] a0,
                              input logic en1, input logic [AW-1:0] a1, input logic ack,
                              input logic eEn, eWr, input logic [AW-1:0] eAddr,
                              input logic eAck0, eAck1);
        vec_t x;
        x.rst = rst; x.en0 = en0; x.wr0 = wr0; x.a0 = a0;
        x.en1 = en1; x.a1 = a1; x.ack = ack;
        x.eEn = eEn; x.eWr = eWr; x.eAddr = eAddr; x.eAck0 = eAck0; x.eAck1 = eAck1;
        vecs.push_back(x);
    endfunction

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t x);
        rst_i       = x.rst;
        m0_enable_i = x.en0; m0_write_i = x.wr0; m0_addr_i = x.a0; m0_data_i = '0;
        m1_enable_i = x.en1; m1_write_i = 1'b0;  m1_addr_i = x.a1; m1_data_i = '0;
        mem_ack_i   = x.ack;
        mem_data_i  = {8{32'hA5A5_5A5A}};
    endtask

    task automatic checkOutput(input string tag, input logic eEn, eWr,
                               input logic [AW-1:0] eAddr, input logic [DW-1:0] eData,
                               input logic eAck0, eAck1);
        chk({tag, ".mem_enable"}, DW'(mem_enable_o), DW'(eEn));
        chk({tag, ".mem_write"},  DW'(mem_write_o),  DW'(eWr));
        chk({tag, ".mem_addr"},   DW'(mem_addr_o),   DW'(eAddr));
        chk({tag, ".mem_data"},   mem_data_o,        eData);
        chk({tag, ".m0_ack"},     DW'(m0_ack_o),     DW'(eAck0));
        chk({tag, ".m1_ack"},     DW'(m1_ack_o),     DW'(eAck1));
        chk({tag, ".m0_data"},    m0_data_o,         mem_data_i);
        chk({tag, ".m1_data"},    m1_data_o,         mem_data_i);
    endtask

    // Advance the model from the inputs present at the edge, then step the clock.
    task automatic tick();
        if (rst_i) begin
            mOwner = -1;
            mLast  = 1'b1;
        end else if (mOwner < 0) begin
            if (m0_enable_i && m1_enable_i) mOwner = mLast ? 0 : 1;
            else if (m0_enable_i)           mOwner = 0;
            else if (m1_enable_i)           mOwner = 1;
            if (mOwner >= 0) mLast = (mOwner == 1);
        end else if ((mOwner == 0 && !m0_enable_i) || (mOwner == 1 && !m1_enable_i)) begin
            mOwner = -1;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkModel();
        logic          eEn, eWr, a0, a1;
        logic [AW-1:0] eAddr;
        logic [DW-1:0] eData;
        eEn = 0; eWr = 0; eAddr = '0; eData = '0; a0 = 0; a1 = 0;
        if (!rst_i && mOwner == 0) begin
            eEn = m0_enable_i; eWr = m0_write_i; eAddr = m0_addr_i; eData = m0_data_i; a0 = mem_ack_i;
        end else if (!rst_i && mOwner == 1) begin
            eEn = m1_enable_i; eWr = m1_write_i; eAddr = m1_addr_i; eData = m1_data_i; a1 = mem_ack_i;
        end
        checkOutput("rand", eEn, eWr, eAddr, eData, a0, a1);
    endtask

    initial begin
        // Only m0 requests; memory answers after ten cycles.
        v(1,0,0,0,0,0,0, 0,0,0,0,0);
        v(1,0,0,0,0,0,0, 0,0,0,0,0);
        v(0,1,0,32'h400,0,0,0, 0,0,0,0,0);
        for (int i = 0; i < 9; i++) v(0,1,0,32'h400,0,0,0, 1,0,32'h400,0,0);
        v(0,1,0,32'h400,0,0,1, 1,0,32'h400,1,0);
        v(0,0,0,32'h400,0,0,0, 0,0,32'h400,0,0);
        // Simultaneous first request: m0 first, one bubble, then m1.
        v(1,0,0,0,0,0,0, 0,0,0,0,0);
        v(0,1,0,32'h100,1,32'h200,0, 0,0,0,0,0);
        v(0,1,0,32'h100,1,32'h200,0, 1,0,32'h100,0,0);
        v(0,1,0,32'h100,1,32'h200,1, 1,0,32'h100,1,0);
        v(0,0,0,32'h100,1,32'h200,0, 0,0,32'h100,0,0);
        v(0,0,0,32'h100,1,32'h200,0, 0,0,0,0,0);
        v(0,0,0,32'h100,1,32'h200,0, 1,0,32'h200,0,0);
        v(0,0,0,32'h100,1,32'h200,1, 1,0,32'h200,0,1);
        v(0,0,0,32'h100,0,32'h200,0, 0,0,32'h200,0,0);
        // Locked writeback then refill under one enable while m1 waits.
        v(0,1,1,32'h800,1,32'h200,0, 0,0,0,0,0);
        v(0,1,1,32'h800,1,32'h200,0, 1,1,32'h800,0,0);
        v(0,1,1,32'h800,1,32'h200,1, 1,1,32'h800,1,0);
        v(0,1,0,32'h400,1,32'h200,0, 1,0,32'h400,0,0);
        v(0,1,0,32'h400,1,32'h200,1, 1,0,32'h400,1,0);
        v(0,0,0,32'h400,1,32'h200,0, 0,0,32'h400,0,0);
        // Fairness: m0 re-asserts immediately but m1 wins, then m0.
        v(0,1,0,32'h400,1,32'h200,0, 0,0,0,0,0);
        v(0,1,0,32'h400,1,32'h200,1, 1,0,32'h200,0,1);
        v(0,1,0,32'h400,0,32'h200,0, 0,0,32'h200,0,0);
        v(0,1,0,32'h400,0,32'h200,0, 0,0,0,0,0);
        v(0,1,0,32'h400,0,32'h200,0, 1,0,32'h400,0,0);
        v(0,0,0,32'h400,0,32'h200,0, 0,0,32'h400,0,0);
        // Reset in the middle of a GRANT1, then a tie goes to m0.
        v(0,0,0,32'h400,1,32'h200,0, 0,0,0,0,0);
        v(0,0,0,32'h400,1,32'h200,0, 1,0,32'h200,0,0);
        v(1,1,0,32'h400,1,32'h200,1, 0,0,0,0,0);
        v(0,1,0,32'h400,1,32'h200,0, 0,0,0,0,0);
        v(0,1,0,32'h400,1,32'h200,0, 1,0,32'h400,0,0);
        v(0,0,0,32'h400,0,32'h200,0, 0,0,32'h400,0,0);
        // Stray ack while idle is dropped and the state stays idle.
        v(0,0,0,32'h400,0,32'h200,1, 0,0,0,0,0);
        v(0,0,0,32'h400,0,32'h200,0, 0,0,0,0,0);
        v(0,0,0,32'h400,1,32'h200,0, 0,0,0,0,0);
        v(0,0,0,32'h400,1,32'h200,0, 1,0,32'h200,0,0);
        v(0,0,0,32'h400,0,32'h200,0, 0,0,32'h200,0,0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].eEn, vecs[i].eWr, vecs[i].eAddr,
                        '0, vecs[i].eAck0, vecs[i].eAck1);
            tick();
        end

        rst_i = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (n > 0) rst_i = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) m0_enable_i = ~m0_enable_i;
            if ($urandom_range(0, 3) == 0) m1_enable_i = ~m1_enable_i;
            if ($urandom_range(0, 3) == 0) m0_addr_i = $urandom;
            if ($urandom_range(0, 3) == 0) m1_addr_i = $urandom;
            m0_write_i = $urandom_range(0, 1);
            m1_write_i = $urandom_range(0, 1);
            m0_data_i  = rand256();
            m1_data_i  = rand256();
            mem_data_i = rand256();
            mem_ack_i  = ($urandom_range(0, 3) == 0);
            #1;
            checkModel();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
